serializador_janela9: RTL

Streams a 9-element window of 8-bit samples as a sequence of single bytes, in the opposite direction to the window input memory. A producer writes one parallel window per handshake. The block double-buffers the windows and emits the bytes in index order 0..8 over a valid/ready byte stream. It sits between the comparator's window stage and any byte-serial consumer, such as a serial memory loader or a UART bridge.

---
 rtl/serializador_janela9.sv | 78 +++++++
 1 files changed

// File: rtl/serializador_janela9.sv
// Double-buffered serializer: one N-sample window in, N single samples out in index order 0..N-1.
// Byte 0 is valid the cycle after accept; in_ready drops only while the pending buffer is full.
module serializador_janela9 #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_idx,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q [N-1:0];
  logic [WIDTH-1:0] p_q [N-1:0];
  logic             p_full_q;
  logic [3:0]       idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      p_full_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !p_full_q) begin
            a_q     <= in_data;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready && idx_q == LAST) begin
            idx_q <= '0;
            // Window done: refill from P first, else bypass a same-cycle input straight into A.
            if (p_full_q) begin
              a_q      <= p_q;
              p_full_q <= 1'b0;
            end else if (in_valid) begin
              a_q <= in_data;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            if (out_ready) idx_q <= idx_q + 4'd1;
            if (in_valid && !p_full_q) begin
              p_q      <= in_data;
              p_full_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = !p_full_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? a_q[idx_q] : '0;
  assign out_idx   = out_valid ? idx_q : 4'd0;
  assign out_first = out_valid && (idx_q == 4'd0);
  assign out_last  = out_valid && (idx_q == LAST);
  assign busy      = (state_q == SEND) || p_full_q;

endmodule
